grill_position_tracker: RTL and testbench

GRILL_POSITION_TRACKER -- requirements
Module: grill_position_tracker

---
 rtl/grill_position_tracker.sv | 71 +++++++
 tb/tb_grill_position_tracker.sv | 128 ++++++++++++
 2 files changed

// File: rtl/grill_position_tracker.sv
// grill_position_tracker: impulse-counting grill position tracker with saturation, stall and motion-error detection
module grill_position_tracker #(
  parameter int P_CNT_W     = 8,
  parameter int P_LIMIT     = 144,
  parameter int P_STALL_CYC = 1000000,
  parameter int P_STALL_W   = 20
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_sensor,
  input  logic [1:0]         i_dir,
  input  logic               i_home,
  output logic [P_CNT_W-1:0] o_count,
  output logic [1:0]         o_pos,
  output logic               o_stall,
  output logic               o_err
);
  typedef enum logic [1:0] {S_IDLE, S_OPEN, S_CLOSE, S_STALL} state_t;
  localparam logic [P_CNT_W-1:0]   LIM   = P_CNT_W'(P_LIMIT);
  localparam logic [P_STALL_W-1:0] T_END = P_STALL_W'(P_STALL_CYC - 1);
  state_t               state, state_n;
  logic                 s0, s1, s_prev, evt;
  logic [1:0]           dir_q;
  logic [P_STALL_W-1:0] timer, timer_n;
  logic [P_CNT_W-1:0]   cnt_n;
  logic                 err_n, at_lim, at_zero, run, dir_chg, hit, home_ok;
  always_comb begin
    at_lim  = o_count == LIM;
    at_zero = o_count == '0;
    run     = (state == S_OPEN && !at_lim) || (state == S_CLOSE && !at_zero);
    dir_chg = i_dir != dir_q;
    hit     = run && timer == T_END && !evt && !dir_chg;
    state_n = state == S_STALL ? ((i_dir == 2'b01 || i_dir == 2'b10) ? S_STALL : S_IDLE) :
              hit ? S_STALL : i_dir == 2'b01 ? S_OPEN : i_dir == 2'b10 ? S_CLOSE : S_IDLE;
    home_ok = i_home && state == S_IDLE;
    cnt_n   = home_ok ? '0 :
              (evt && state == S_OPEN && !at_lim) ? o_count + 1'b1 :
              (evt && state == S_CLOSE && !at_zero) ? o_count - 1'b1 : o_count;
    err_n   = !home_ok && (o_err || (evt && (state == S_IDLE || (state == S_OPEN && at_lim) ||
                                              (state == S_CLOSE && at_zero))));
    timer_n = (evt || dir_chg || !run) ? '0 : timer + 1'b1;
  end
  // evt is registered so a count update lands three edges after the sensor is first sampled
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s0 <= 1'b0;
      s1 <= 1'b0;
      s_prev <= 1'b0;
      evt <= 1'b0;
      dir_q <= 2'b00;
      state <= S_IDLE;
      timer <= '0;
      o_count <= '0;
      o_pos <= 2'b00;
      o_stall <= 1'b0;
      o_err <= 1'b0;
    end else begin
      s0 <= i_sensor;
      s1 <= s0;
      s_prev <= s1;
      evt <= s1 && !s_prev;
      dir_q <= i_dir;
      state <= state_n;
      timer <= timer_n;
      o_count <= cnt_n;
      o_stall <= state_n == S_STALL;
      o_err <= err_n;
      o_pos <= (state_n == S_STALL || err_n) ? 2'b11 : cnt_n == '0 ? 2'b00 : cnt_n == LIM ? 2'b01 : 2'b10;
    end
  end
endmodule

// File: tb/tb_grill_position_tracker.sv
// tb_grill_position_tracker: scoreboard bench with a cycle-level reference model of the tracker rules
module tb_grill_position_tracker;
  localparam int LIM = 4;
  localparam int STALL = 10;
  logic       clk = 0, rst = 0, sensor = 0, home = 0;
  logic [1:0] dir = 0;
  logic [7:0] o_count;
  logic [1:0] o_pos;
  logic       o_stall, o_err;
  int total = 0, bad = 0;
  typedef struct {int cnt; int pos; int st; int er;} exp_t;
  exp_t q[$];
  int m_cnt = 0, m_timer = 0, m_mode = 0, m_err = 0, m_stall = 0, m_pdir = 0;
  bit h[4];

  grill_position_tracker #(.P_CNT_W(8), .P_LIMIT(LIM), .P_STALL_CYC(STALL), .P_STALL_W(4)) dut (
    .i_clk(clk), .i_rst(rst), .i_sensor(sensor), .i_dir(dir), .i_home(home),
    .o_count(o_count), .o_pos(o_pos), .o_stall(o_stall), .o_err(o_err));

  always #5 clk = ~clk;

  // modes: 0 idle, 1 open, 2 close, 3 stalled; h[k] is the sensor sample k+1 edges ago
  task automatic model(input int d, input bit s, input bit hm, input bit r);
    exp_t e;
    bit ev, run, chg, hit, hok;
    int nm;
    if (r) begin
      m_cnt = 0; m_timer = 0; m_mode = 0; m_err = 0; m_stall = 0; m_pdir = 0;
      h = '{0, 0, 0, 0};
    end else begin
      ev  = h[2] && !h[3];
      run = (m_mode == 1 && m_cnt < LIM) || (m_mode == 2 && m_cnt > 0);
      chg = d != m_pdir;
      hit = run && m_timer == STALL - 1 && !ev && !chg;
      if (m_mode == 3) nm = (d == 1 || d == 2) ? 3 : 0;
      else nm = hit ? 3 : d == 1 ? 1 : d == 2 ? 2 : 0;
      hok = hm && m_mode == 0;
      if (hok) begin
        m_cnt = 0; m_err = 0;
      end else if (ev) begin
        if (m_mode == 0) m_err = 1;
        else if (m_mode == 1) begin if (m_cnt < LIM) m_cnt++; else m_err = 1; end
        else if (m_mode == 2) begin if (m_cnt > 0) m_cnt--; else m_err = 1; end
      end
      m_timer = (ev || chg || !run) ? 0 : m_timer + 1;
      m_mode = nm;
      m_stall = nm == 3;
      m_pdir = d;
      h[3] = h[2]; h[2] = h[1]; h[1] = h[0]; h[0] = s;
    end
    e.cnt = m_cnt; e.st = m_stall; e.er = m_err;
    e.pos = (m_stall || m_err) ? 3 : m_cnt == 0 ? 0 : m_cnt == LIM ? 1 : 2;
    q.push_back(e);
  endtask

  task automatic cyc(input int d, input bit s, input bit hm, input bit r);
    @(negedge clk);
    dir = 2'(d); sensor = s; home = hm; rst = r;
    model(d, s, hm, r);
  endtask

  task automatic pulse(input int d);
    cyc(d, 1, 0, 0); cyc(d, 1, 0, 0);
    repeat (3) cyc(d, 0, 0, 0);
  endtask

  task automatic chk(input string n, input int a, input int b);
    total++;
    if (a != b) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d at %0t", n, a, b, $time);
    end
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("count", int'(o_count), e.cnt);
      chk("pos", int'(o_pos), e.pos);
      chk("stall", int'(o_stall), e.st);
      chk("err", int'(o_err), e.er);
    end
  end

  initial begin
    int d;
    bit s;
    repeat (2) cyc(0, 0, 0, 1);
    repeat (2) cyc(1, 0, 0, 0);
    repeat (4) pulse(1);
    pulse(1);
    repeat (2) cyc(0, 0, 0, 1);
    repeat (2) pulse(1);
    repeat (14) cyc(2, 0, 0, 0);
    repeat (2) pulse(2);
    repeat (3) cyc(0, 0, 0, 0);
    pulse(0);
    cyc(0, 0, 1, 0);
    repeat (2) cyc(0, 0, 0, 0);
    repeat (2) cyc(2, 0, 0, 0);
    pulse(2);
    repeat (2) cyc(0, 0, 0, 1);
    cyc(1, 0, 0, 0);
    repeat (3) pulse(1);
    cyc(1, 1, 0, 0); cyc(1, 1, 0, 0);
    cyc(1, 0, 0, 1);
    repeat (4) cyc(1, 0, 0, 0);
    d = 0; s = 0;
    repeat (3000) begin
      bit r;
      if ($urandom_range(15) == 0) d = int'($urandom_range(3));
      if ($urandom_range(7) == 0) s = !s;
      r = $urandom_range(299) == 0;
      if (r) s = 0;
      cyc(d, s, $urandom_range(19) == 0, r);
    end
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    #2;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain got=%0d want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
